// File: rtl/i2s_transmitter_pkg.sv
// ============================================================================
// Module   : i2s_transmitter_pkg
// Brief    : Shared audio constants and slot bit map for the I2S TX/RX pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_transmitter_pkg;

    localparam int C_SCLK_PERIOD_DEF = 36;
    localparam int C_I2S_PERIOD_DEF  = 64;
    localparam int C_SAMPLE_W        = 16;
    localparam int C_IDX_W           = $clog2(C_SAMPLE_W);

    localparam int C_SLOT_L_FIRST = 1;
    localparam int C_SLOT_L_LAST  = 16;
    localparam int C_SLOT_R_FIRST = 33;
    localparam int C_SLOT_R_LAST  = 48;

    typedef logic [C_SAMPLE_W-1:0] sample_t;

    // Serial bit for frame position c: MSB-justified, one sclk after the ws edge.
    function automatic logic slot_bit(input sample_t s, input int c);
        logic r_bit;
        r_bit = 1'b0;
        if (c >= C_SLOT_L_FIRST && c <= C_SLOT_L_LAST)
            r_bit = s[C_IDX_W'(C_SLOT_L_LAST - c)];
        else if (c >= C_SLOT_R_FIRST && c <= C_SLOT_R_LAST)
            r_bit = s[C_IDX_W'(C_SLOT_R_LAST - c)];
        return r_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_clock_gen.sv
// ============================================================================
// Module   : i2s_clock_gen
// Brief    : I2S bit clock, word select and frame position generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_clock_gen
    import i2s_transmitter_pkg::*;
#(
    parameter int SCLK_PERIOD = C_SCLK_PERIOD_DEF,
    parameter int I2S_PERIOD  = C_I2S_PERIOD_DEF
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    output logic                          sclk,
    output logic                          ws,
    output logic [$clog2(I2S_PERIOD)-1:0] cycle,
    output logic                          falling_event,
    output logic                          frame_start
);

    localparam int C_SCW = $clog2(SCLK_PERIOD);
    localparam int C_CW  = $clog2(I2S_PERIOD);

    localparam logic [C_SCW-1:0] C_SCLK_LAST = C_SCW'(SCLK_PERIOD - 1);
    localparam logic [C_SCW-1:0] C_SCLK_RISE = C_SCW'(SCLK_PERIOD / 2 - 1);
    localparam logic [C_CW-1:0]  C_CYC_LAST  = C_CW'(I2S_PERIOD - 1);
    localparam logic [C_CW-1:0]  C_CYC_HALF  = C_CW'(I2S_PERIOD / 2 - 1);

    logic [C_SCW-1:0] r_sclk_cycle;
    logic [C_CW-1:0]  r_cycle;
    logic             r_sclk;
    logic             r_ws;

    assign falling_event = (r_sclk_cycle == C_SCLK_LAST);
    assign frame_start   = falling_event && (r_cycle == C_CYC_LAST);

    // Reset parks both counters on their last value so the first clock is a frame start.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sclk_cycle <= C_SCLK_LAST;
            r_cycle      <= C_CYC_LAST;
            r_sclk       <= 1'b1;
            r_ws         <= 1'b0;
        end else begin
            r_sclk_cycle <= falling_event ? '0 : r_sclk_cycle + C_SCW'(1);
            if (r_sclk_cycle == C_SCLK_RISE)
                r_sclk <= 1'b1;
            if (falling_event) begin
                r_sclk  <= 1'b0;
                r_cycle <= (r_cycle == C_CYC_LAST) ? '0 : r_cycle + C_CW'(1);
                if (r_cycle == C_CYC_HALF)
                    r_ws <= 1'b1;
                else if (r_cycle == C_CYC_LAST)
                    r_ws <= 1'b0;
            end
        end
    end

    assign sclk  = r_sclk;
    assign ws    = r_ws;
    assign cycle = r_cycle;

endmodule

`default_nettype wire

// File: rtl/i2s_transmitter.sv
// ============================================================================
// Module   : i2s_transmitter
// Brief    : 16-bit I2S transmitter with a single-entry hold buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int SCLK_PERIOD = C_SCLK_PERIOD_DEF,
    parameter int I2S_PERIOD  = C_I2S_PERIOD_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [C_SAMPLE_W-1:0] data_in,
    input  logic                  data_valid_in,
    output logic                  ready_out,
    output logic                  sclk_out,
    output logic                  ws_out,
    output logic                  sdata_out,
    output logic                  underrun_out
);

    localparam int C_CW = $clog2(I2S_PERIOD);

    logic            w_sclk;
    logic            w_ws;
    logic            w_falling;
    logic            w_frame_start;
    logic [C_CW-1:0] w_cycle;
    logic [C_CW-1:0] w_cycle_next;
    logic            w_accept;

    sample_t r_buf;
    sample_t r_sample;
    logic    r_buf_full;
    logic    r_sdata;
    logic    r_underrun;

    i2s_clock_gen #(
        .SCLK_PERIOD (SCLK_PERIOD),
        .I2S_PERIOD  (I2S_PERIOD)
    ) u_clock_gen (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .sclk          (w_sclk),
        .ws            (w_ws),
        .cycle         (w_cycle),
        .falling_event (w_falling),
        .frame_start   (w_frame_start)
    );

    assign w_accept     = data_valid_in && !r_buf_full;
    assign w_cycle_next = w_frame_start ? '0 : w_cycle + C_CW'(1);

    // A full buffer cannot accept, so frame-start load and acceptance never collide.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_sample   <= '0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frame_start && !r_buf_full;
            if (w_frame_start && r_buf_full) begin
                r_sample   <= r_buf;
                r_buf_full <= 1'b0;
            end else if (w_accept) begin
                r_buf      <= data_in;
                r_buf_full <= 1'b1;
            end
            if (w_falling)
                r_sdata <= slot_bit(r_sample, int'(w_cycle_next));
        end
    end

    assign ready_out    = !r_buf_full;
    assign sclk_out     = w_sclk;
    assign ws_out       = w_ws;
    assign sdata_out    = r_sdata;
    assign underrun_out = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
// ============================================================================
// Module   : tb_i2s_transmitter
// Brief    : Self-checking bench for i2s_transmitter against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_transmitter;

    localparam int SP = 36;
    localparam int FP = 64;
    localparam logic [63:0] C_SLOT_MASK = 64'h0001_FFFE_0001_FFFE;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] data_in = '0;
    logic        data_valid_in = 1'b0;
    logic        ready_out, sclk_out, ws_out, sdata_out, underrun_out;

    i2s_transmitter #(.SCLK_PERIOD(SP), .I2S_PERIOD(FP)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .ready_out     (ready_out),
        .sclk_out      (sclk_out),
        .ws_out        (ws_out),
        .sdata_out     (sdata_out),
        .underrun_out  (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int run = 0;
    bit model_ok = 0;

    bit          m_full;
    logic [15:0] m_buf, m_S;
    logic        exp_sclk, exp_ws, exp_sdata, exp_under, exp_ready;

    logic [63:0] cap [0:15];
    int uq0[$];
    int uq1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d run=%0d)", name, act, expv, k, run);
        end
    endtask

    function automatic logic map_bit(input logic [15:0] s, input int c);
        if (c >= 1 && c <= 16)  return s[4'(16 - c)];
        if (c >= 33 && c <= 48) return s[4'(48 - c)];
        return 1'b0;
    endfunction

    // Timeline model: k counts clocks since reset release.
    always @(posedge clk_in) begin : model
        int ph, cyc;
        bit fs, acc, und;
        if (rst_in) begin
            k = 0; m_full = 0; m_buf = '0; m_S = '0;
            exp_sclk = 1; exp_ws = 0; exp_sdata = 0; exp_under = 0; exp_ready = 1;
            model_ok = 1;
        end else begin
            k++;
            ph  = (k - 1) % SP;
            cyc = ((k - 1) / SP) % FP;
            fs  = (ph == 0) && (cyc == 0);
            acc = data_valid_in && !m_full;
            und = fs && !m_full;
            if (fs && m_full) begin
                m_S = m_buf; m_full = 0;
            end else if (acc) begin
                m_buf = data_in; m_full = 1;
            end
            exp_sclk  = (ph >= SP / 2);
            exp_ws    = (cyc >= FP / 2);
            exp_sdata = map_bit(m_S, cyc);
            exp_under = und;
            exp_ready = !m_full;
        end
    end

    logic prev_sclk, prev_ws, prev_sdata;
    int   sclk_len, last_rise_k, last_chg_k, rises;

    always @(negedge clk_in) begin : compare
        int n, f, c;
        bit rise;
        if (model_ok) begin
            chk("sclk_out", sclk_out, exp_sclk);
            chk("ws_out", ws_out, exp_ws);
            chk("sdata_out", sdata_out, exp_sdata);
            chk("underrun_out", underrun_out, exp_under);
            chk("ready_out", ready_out, exp_ready);
            if (k == 0) begin
                sclk_len = 0; last_rise_k = -100; last_chg_k = -100; rises = 0;
            end else begin
                rise = sclk_out && !prev_sclk;
                if (sclk_out == prev_sclk) sclk_len++;
                else begin
                    if (k > 1) chk(prev_sclk ? "sclk_high_len" : "sclk_low_len", sclk_len, SP / 2);
                    sclk_len = 1;
                end
                if (rise) begin
                    chk("sdata_setup", (k - last_chg_k) > 1, 1);
                    last_rise_k = k;
                    rises++;
                    n = (k - 1) / SP; f = n / FP; c = n % FP;
                    if (f < 8) cap[4'(run * 8 + f)][6'(c)] = sdata_out;
                end
                if (sdata_out !== prev_sdata) begin
                    chk("sdata_hold", (k - last_rise_k) > 1, 1);
                    last_chg_k = k;
                end
                if (ws_out !== prev_ws) begin
                    chk("ws_period_sclks", rises, FP / 2);
                    rises = 0;
                end
                if (underrun_out) begin
                    if (run == 0) uq0.push_back(k); else uq1.push_back(k);
                end
            end
            prev_sclk = sclk_out; prev_ws = ws_out; prev_sdata = sdata_out;
        end
    end

    task automatic wait_k(input int t);
        while (k < t) @(negedge clk_in);
    endtask

    task automatic chk_frame(input string name, input int idx, input logic [15:0] s);
        logic [15:0] l, r;
        for (int c = 1; c <= 16; c++)  l[4'(16 - c)] = cap[4'(idx)][6'(c)];
        for (int c = 33; c <= 48; c++) r[4'(48 - c)] = cap[4'(idx)][6'(c)];
        chk({name, "_left"}, l, s);
        chk({name, "_right"}, r, s);
        chk({name, "_idle_zero"}, cap[4'(idx)] & ~C_SLOT_MASK, 0);
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    initial begin : watchdog
        #1ms;
        errors++;
        $display("FAIL watchdog: got timeout expected completion (k=%0d)", k);
        finish_sim();
    end

    initial begin : stim
        int kr;
        int exp_u0 [4] = '{1, 2305, 11521, 16129};
        int exp_u1 [2] = '{1, 2305};
        for (int i = 0; i < 16; i++) cap[i] = '0;

        @(negedge clk_in);
        chk("rst_sclk", sclk_out, 1);
        chk("rst_ws", ws_out, 0);
        chk("rst_ready", ready_out, 1);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 0;

        // Single sample: accepted in one clock, sent in frame 2.
        wait_k(2404);
        chk("ready_before_offer", ready_out, 1);
        data_in = 16'hA5C3; data_valid_in = 1;
        @(negedge clk_in);
        data_valid_in = 0;
        chk("ready_after_accept", ready_out, 0);

        // Back-to-back: second sample waits for the frame-3 load.
        wait_k(5000);
        data_in = 16'h1234; data_valid_in = 1;
        @(negedge clk_in);
        data_in = 16'h5678;
        kr = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            if (ready_out) begin kr = k; break; end
        end
        chk("ready_rise_k", kr, 6913);
        @(negedge clk_in);
        data_valid_in = 0;
        chk("held_sample_accepted", ready_out, 0);

        // Acceptance exactly on the frame-5 start with an empty buffer.
        wait_k(11520);
        data_in = 16'h8001; data_valid_in = 1;
        @(negedge clk_in);
        data_valid_in = 0;
        chk("fs_accept_underrun", underrun_out, 1);
        chk("fs_accept_ready", ready_out, 0);

        // Reset mid-frame (cycle 20 of frame 7) with a full buffer.
        wait_k(16200);
        data_in = 16'hDEAD; data_valid_in = 1;
        @(negedge clk_in);
        data_valid_in = 0;
        wait_k(16860);
        chk("pre_reset_full", ready_out, 0);
        rst_in = 1;
        @(negedge clk_in);
        chk("midrst_sclk", sclk_out, 1);
        chk("midrst_ws", ws_out, 0);
        chk("midrst_sdata", sdata_out, 0);
        chk("midrst_underrun", underrun_out, 0);
        chk("midrst_ready", ready_out, 1);
        @(negedge clk_in);
        run = 1;
        rst_in = 0;
        wait_k(4600);

        chk_frame("f0", 0, 16'h0000);
        chk_frame("f1", 1, 16'h0000);
        chk_frame("f2", 2, 16'hA5C3);
        chk_frame("f3", 3, 16'h1234);
        chk_frame("f4", 4, 16'h5678);
        chk_frame("f5_repeat", 5, 16'h5678);
        chk_frame("f6", 6, 16'h8001);
        chk_frame("r1_f0", 8, 16'h0000);
        chk_frame("r1_f1", 9, 16'h0000);

        chk("underrun_count_run0", uq0.size(), 4);
        for (int i = 0; i < 4 && i < uq0.size(); i++) chk("underrun_k_run0", uq0[i], exp_u0[i]);
        chk("underrun_count_run1", uq1.size(), 2);
        for (int i = 0; i < 2 && i < uq1.size(); i++) chk("underrun_k_run1", uq1[i], exp_u1[i]);

        finish_sim();
    end

endmodule

`default_nettype wire
